// File: rtl/inst_mem_pipe_if.sv
// Fetch/response handshake, flush and program-load bus for the pipelined instruction memory.
interface inst_mem_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_inst;
    logic                  rsp_err;
    logic                  flush;
    logic                  load_en;
    logic [IDX_W-1:0]      load_idx;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, load_en, load_idx, load_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, load_en, load_idx, load_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/inst_mem_pipe.sv
// Synchronous-read instruction memory with 1-cycle valid/ready response, flush and load port.
// Optional macro IMEM_ADDR_CHECK_EN flags misaligned / out-of-range fetches instead of wrapping.
module inst_mem_pipe #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h00000013)
) (
    input  logic           clk,
    input  logic           rst,
    inst_mem_pipe_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Boot program is the power-up image; reset deliberately leaves it alone.
    word_t mem [DEPTH] = '{
        0:  DATA_WIDTH'(32'h00000013), 1:  DATA_WIDTH'(32'h00500113),
        2:  DATA_WIDTH'(32'h00C00193), 3:  DATA_WIDTH'(32'h00918393),
        4:  DATA_WIDTH'(32'h0023E233), 5:  DATA_WIDTH'(32'h0041F2B3),
        6:  DATA_WIDTH'(32'h004282B3), 7:  DATA_WIDTH'(32'h005104B3),
        8:  DATA_WIDTH'(32'h00100193), 9:  DATA_WIDTH'(32'h007120A3),
        10: DATA_WIDTH'(32'h0092A023), 11: DATA_WIDTH'(32'h00112783),
        12: DATA_WIDTH'(32'h0002AA03),
        default: NOP_WORD
    };

    logic             rsp_valid_q;
    word_t            rsp_inst_q;
    logic             rsp_err_q;
    logic             accept;
    logic [IDX_W-1:0] rd_idx;
    logic             addr_err;

    assign rd_idx        = bus.req_addr[IDX_W+1:2];
    assign bus.req_ready = !bus.flush && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef IMEM_ADDR_CHECK_EN
    assign addr_err = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[ADDR_WIDTH-1:IDX_W+2]);
`else
    // Byte offset and upper bits are intentionally dropped so the index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[ADDR_WIDTH-1:IDX_W+2]};
    assign addr_err         = 1'b0;
`endif

    // Load port runs regardless of reset, flush or stall.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.load_idx] <= bus.load_data;
        end
    end

    // Response register; NBA ordering gives read-before-write on a same-word load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= NOP_WORD;
            rsp_err_q   <= 1'b0;
        end else if (bus.flush) begin
            rsp_valid_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= addr_err ? NOP_WORD : mem[rd_idx];
            rsp_err_q   <= addr_err;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_inst  = rsp_inst_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
